// File: rtl/btn_conditioner.sv
// Per-channel button conditioner: 2-FF synchroniser, debounce, press/release strobes.
// Auto-repeat strobes are built only when BTN_REPEAT_EN is defined.
module btn_conditioner #(
    parameter int unsigned N             = 5,
    parameter int unsigned DB_CYCLES     = 500000,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000,
    parameter int unsigned CNT_W         = 25
) (
    input  logic         CCLK,
    input  logic         rst_n,
    input  logic [N-1:0] btn_in,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] btn_press,
    output logic [N-1:0] btn_release,
    output logic [N-1:0] btn_repeat,
    output logic [N-1:0] btn_event
);

    localparam longint unsigned CNT_SPAN = 64'd1 << CNT_W;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    // Reject configurations the counters cannot represent.
    if (DB_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
        64'(DB_CYCLES) >= CNT_SPAN || 64'(REPEAT_DELAY) >= CNT_SPAN ||
        64'(REPEAT_PERIOD) >= CNT_SPAN) begin : g_cfg_err
        $error("btn_conditioner: invalid counter configuration");
    end

    logic [N-1:0]     sync1;
    logic [N-1:0]     sync2;
    logic [CNT_W-1:0] dcnt     [N];
    logic [CNT_W-1:0] dcnt_nxt [N];
    logic [N-1:0]     level_nxt;
    logic [N-1:0]     press_nxt;
    logic [N-1:0]     release_nxt;

    // Debounce: a level change is accepted after DB_CYCLES consecutive mismatching samples.
    always_comb begin
        level_nxt   = btn_level;
        press_nxt   = '0;
        release_nxt = '0;
        for (int i = 0; i < int'(N); i++) begin
            dcnt_nxt[i] = '0;
            if (sync2[i] != btn_level[i]) begin
                if (dcnt[i] == DB_LAST) begin
                    level_nxt[i]   = sync2[i];
                    press_nxt[i]   = sync2[i];
                    release_nxt[i] = ~sync2[i];
                end else begin
                    dcnt_nxt[i] = dcnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CCLK) begin
        if (!rst_n) begin
            sync1       <= '0;
            sync2       <= '0;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < int'(N); i++) begin
                dcnt[i] <= '0;
            end
        end else begin
            sync1       <= btn_in;
            sync2       <= sync1;
            btn_level   <= level_nxt;
            btn_press   <= press_nxt;
            btn_release <= release_nxt;
            for (int i = 0; i < int'(N); i++) begin
                dcnt[i] <= dcnt_nxt[i];
            end
        end
    end

`ifdef BTN_REPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rcnt     [N];
    logic [CNT_W-1:0] rcnt_nxt [N];
    logic [N-1:0]     rfirst;
    logic [N-1:0]     rfirst_nxt;
    logic [N-1:0]     repeat_nxt;

    // Repeat timer: restarts on press, uses the delay once then the period; idle unless held.
    always_comb begin
        repeat_nxt = '0;
        rfirst_nxt = rfirst;
        for (int i = 0; i < int'(N); i++) begin
            rcnt_nxt[i] = '0;
            if (press_nxt[i]) begin
                rfirst_nxt[i] = 1'b1;
            end else if (level_nxt[i]) begin
                if (rcnt[i] == (rfirst[i] ? DELAY_LAST : PERIOD_LAST)) begin
                    repeat_nxt[i] = 1'b1;
                    rfirst_nxt[i] = 1'b0;
                end else begin
                    rcnt_nxt[i] = rcnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CCLK) begin
        if (!rst_n) begin
            rfirst     <= '0;
            btn_repeat <= '0;
            for (int i = 0; i < int'(N); i++) begin
                rcnt[i] <= '0;
            end
        end else begin
            rfirst     <= rfirst_nxt;
            btn_repeat <= repeat_nxt;
            for (int i = 0; i < int'(N); i++) begin
                rcnt[i] <= rcnt_nxt[i];
            end
        end
    end
`else
    assign btn_repeat = '0;
`endif

    assign btn_event = btn_press | btn_repeat;

endmodule

// File: tb/tb_btn_conditioner.sv
// Randomised + directed bench for btn_conditioner against a sample-window reference model.
module tb_btn_conditioner;

    localparam int unsigned N  = 4;
    localparam int unsigned DB = 4;
    localparam int unsigned RD = 10;
    localparam int unsigned RP = 3;
    localparam int unsigned CW = 8;
    localparam int unsigned HD = DB + 2;

    logic         CCLK;
    logic         rst_n;
    logic [N-1:0] btn_in;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_repeat;
    logic [N-1:0] btn_event;

    btn_conditioner #(
        .N(N), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(CW)
    ) dut (
        .CCLK(CCLK), .rst_n(rst_n), .btn_in(btn_in),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .btn_repeat(btn_repeat), .btn_event(btn_event)
    );

    initial CCLK = 1'b0;
    always #5 CCLK = ~CCLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rep_cnt;

    // Model: raw-sample history; index 0 is the newest sample taken at an edge.
    logic [N-1:0] rawh [HD];
    logic [N-1:0] m_level, m_press, m_release, m_repeat;
    int           ptime [N];
    bit           held  [N];

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [N-1:0] din, input logic rn);
        bit all_diff;
        m_press   = '0;
        m_release = '0;
        m_repeat  = '0;
        if (!rn) begin
            for (int h = 0; h < int'(HD); h++) rawh[h] = '0;
            m_level = '0;
            for (int i = 0; i < int'(N); i++) held[i] = 1'b0;
        end else begin
            for (int h = int'(HD) - 1; h > 0; h--) rawh[h] = rawh[h-1];
            rawh[0] = din;
            for (int i = 0; i < int'(N); i++) begin
                // Samples reach the debouncer two edges late; the last DB of them must all disagree.
                all_diff = 1'b1;
                for (int h = 2; h < int'(HD); h++) begin
                    if (rawh[h][i] == m_level[i]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_level[i] = ~m_level[i];
                    if (m_level[i]) begin
                        m_press[i] = 1'b1;
                        held[i]    = 1'b1;
                        ptime[i]   = cyc;
                    end else begin
                        m_release[i] = 1'b1;
                        held[i]      = 1'b0;
                    end
                end
`ifdef BTN_REPEAT_EN
                else if (held[i] && (cyc - ptime[i]) >= int'(RD) &&
                         ((cyc - ptime[i] - int'(RD)) % int'(RP)) == 0) begin
                    m_repeat[i] = 1'b1;
                end
`endif
            end
        end
    endtask

    task automatic step(input logic [N-1:0] din, input logic rn);
        btn_in = din;
        rst_n  = rn;
        @(posedge CCLK);
        #1;
        cyc++;
        model_edge(din, rn);
        chk("level",   btn_level,   m_level);
        chk("press",   btn_press,   m_press);
        chk("release", btn_release, m_release);
        chk("repeat",  btn_repeat,  m_repeat);
        chk("event",   btn_event,   m_press | m_repeat);
    endtask

    task automatic hold(input logic [N-1:0] din, input int n);
        for (int k = 0; k < n; k++) step(din, 1'b1);
    endtask

    initial begin
        logic [N-1:0] cur;
        logic [N-1:0] zero_v;
        zero_v = '0;
        btn_in = '0;
        rst_n  = 1'b0;
        for (int h = 0; h < int'(HD); h++) rawh[h] = '0;
        m_level = '0;
        for (int i = 0; i < int'(N); i++) begin
            held[i]  = 1'b0;
            ptime[i] = 0;
        end

        // Reset with all buttons pressed, then fresh press after reset release.
        for (int k = 0; k < 3; k++) begin
            step(4'hF, 1'b0);
            chk("rst_all_zero", btn_level | btn_press | btn_release | btn_repeat | btn_event, zero_v);
        end
        hold(4'hF, 5);
        chk("rst_no_early_press", btn_press, 4'h0);
        step(4'hF, 1'b1);
        chk("rst_press", btn_press, 4'hF);
        step(4'hF, 1'b1);
        chk("rst_press_one_cycle", btn_press, 4'h0);
        hold(4'h0, 8);
        step(4'h0, 1'b0);

        // Clean press on channel 3.
        hold(4'b1000, 5);
        step(4'b1000, 1'b1);
        chk("clean_level", btn_level, 4'b1000);
        chk("clean_press", btn_press, 4'b1000);
        hold(4'b1000, 3);

        // Release on channel 3.
        hold(4'b0000, 5);
        step(4'b0000, 1'b1);
        chk("rel_strobe", btn_release, 4'b1000);
        chk("rel_level",  btn_level,   4'b0000);
        chk("rel_no_press", btn_press, 4'b0000);

        // Bounce on channel 0: 3 high / 1 low five times, then held.
        for (int b = 0; b < 5; b++) begin
            hold(4'b0001, 3);
            hold(4'b0000, 1);
        end
        hold(4'b0001, 8);
        hold(4'b0000, 8);

        // Same rise, with reset pulsed mid-window.
        hold(4'b0001, 4);
        step(4'b0001, 1'b0);
        hold(4'b0001, 10);
        hold(4'b0000, 8);

        // Auto-repeat on channel 1: count repeats in the 30 cycles after the press cycle.
        hold(4'b0010, 5);
        step(4'b0010, 1'b1);
        chk("rep_press", btn_press, 4'b0010);
        rep_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            step(4'b0010, 1'b1);
            rep_cnt += int'(btn_repeat[1]);
        end
`ifdef BTN_REPEAT_EN
        chk("rep_count", N'(rep_cnt), N'(7));
`else
        chk("rep_count", N'(rep_cnt), N'(0));
`endif
        rep_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step(4'b0000, 1'b1);
            rep_cnt += int'(btn_repeat[1]);
        end
        chk("rep_after_release", N'(rep_cnt), N'(0));

        // Simultaneous: ch0/ch2 rise while ch1 falls.
        hold(4'b0010, 8);
        hold(4'b0101, 5);
        step(4'b0101, 1'b1);
        chk("sim_press",   btn_press,   4'b0101);
        chk("sim_release", btn_release, 4'b0010);
        hold(4'b0000, 8);

        // Random: bouncy phase, then long-hold phase, occasional reset.
        cur = '0;
        for (int k = 0; k < 700; k++) begin
            for (int i = 0; i < int'(N); i++) begin
                if ($urandom_range(0, (k < 250) ? 3 : 19) == 0) cur[i] = ~cur[i];
            end
            step(cur, ($urandom_range(0, 149) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
